exu_stage: RTL and testbench
============================

// Module: exu_stage
// PURPOSE
// Execute stage between decode (ID) and LSU/writeback. Selects ALU operands, drives one
// alu instance, resolves branches/jumps and holds the result in a single-entry output
// register with a valid/ready handshake on both sides. Issues a one-cycle PC redirect.
// PARAMETERS
// DATA_WIDTH  `DATA_WIDTH  datapath width (32 or 64)
// ARGS_WIDTH  `ARGS_WIDTH  width of ALU type code (`ALU_TYPE_* encodings)
// PORTS
// i_clk            in   1           clock; all state on rising edge
// i_rst            in   1           reset: one clock, synchronous, active-high
// i_flush          in   1           kill held entry and any incoming instruction
// i_id_valid       in   1           ID presents an instruction
// o_id_ready       out  1           stage accepts this cycle
// i_id_pc          in   DATA_WIDTH  instruction PC
// i_id_rs1_data    in   DATA_WIDTH  rs1 value
// i_id_rs2_data    in   DATA_WIDTH  rs2 value (also store data)
// i_id_imm         in   DATA_WIDTH  sign-extended immediate
// i_id_alu_type    in   ARGS_WIDTH  ALU operation
// i_id_src1_pc     in   1           0: op1 = rs1, 1: op1 = pc
// i_id_src2_imm    in   1           0: op2 = rs2, 1: op2 = imm
// i_id_br/jal/jalr in   1 each      conditional branch / JAL / JALR (one-hot or none)
// i_id_rd_addr     in   5           destination register; i_id_rd_wen in 1: write enable
// o_ex_valid       out  1           output entry valid
// i_ex_ready       in   1           consumer takes entry this cycle
// o_ex_pc/o_ex_res/o_ex_rs2_data  out DATA_WIDTH  registered pc, result, store data
// o_ex_rd_addr     out  5           registered rd; o_ex_rd_wen out 1 registered wen
// o_ex_redirect    out  1           one-cycle pulse: fetch must restart at o_ex_redirect_pc
// o_ex_redirect_pc out  DATA_WIDTH  redirect target
// BEHAVIOUR
// - Reset: o_ex_valid=0, o_ex_redirect=0, all data outputs 0. Reset overrides flush/handshake.
// - States EMPTY (o_ex_valid=0), FULL (o_ex_valid=1). accept = i_id_valid & o_id_ready & ~i_flush.
// - o_id_ready = (~o_ex_valid | i_ex_ready) & ~o_ex_redirect & ~i_rst.
// - EMPTY->FULL on accept; FULL->FULL on accept (replace); FULL->EMPTY on i_ex_ready & ~accept.
// - i_flush: next cycle o_ex_valid=0, o_ex_redirect=0, regardless of ready/valid.
// - FULL & ~i_ex_ready: all o_ex_* held bit-stable.
// - Operands: op1 = src1_pc ? pc : rs1; op2 = src2_imm ? imm : rs2. Branch forces rs1/rs2.
// - Latency 1: result of instruction accepted at edge N visible at o_ex_* after edge N.
// - o_ex_res: ALU result; JAL/JALR: pc+4 (DATA_WIDTH wrap, no carry out); branch: 0, wen=0.
// - Branch: taken = alu_res[0] with branch ALU type; target = pc + imm (wraps).
// - JAL: target = pc + imm. JALR: target = (rs1 + imm) & ~1 (ALU_TYPE_JALR path).
// - o_ex_redirect registered with the entry: 1 for exactly one cycle after accepting a taken
//   branch/JAL/JALR, even if consumer stalls; o_id_ready=0 during that cycle (wrong-path drop).
// - ALU overflow/neg/zero flags unused; no exceptions raised (misalignment checked in IF).
// - Simultaneous i_ex_ready and accept in FULL: old entry leaves, new loads, no bubble.
// TESTING
// - ADD x3=7+5, i_ex_ready=1 -> next cycle o_ex_valid=1, o_ex_res=12, rd=3, wen=1.
// - Hold i_ex_ready=0 3 cycles while FULL -> o_id_ready=0, o_ex_* constant; release -> drains.
// - BEQ rs1=rs2=4, pc=0x100, imm=0x20 -> redirect=1 one cycle, redirect_pc=0x120, wen=0.
// - JALR rs1=0x203, imm=0x10, pc=0x80 -> redirect_pc=0x212, o_ex_res=0x84.
// - i_flush with FULL and i_id_valid=1 -> next cycle o_ex_valid=0, no redirect, ID not taken.
// - i_rst mid-stall with FULL -> o_ex_valid=0, all outputs 0; back-to-back ADDs after reset, no bubble.

Source files
------------

// File: rtl/exu_stage.sv
// Execute stage: operand select, one ALU, branch/jump resolution and a single-entry
// output register with valid/ready on both sides plus a one-cycle PC redirect pulse.
module exu_alu #(
  parameter int DATA_WIDTH = 32,
  parameter int ARGS_WIDTH = 5
) (
  input  logic [ARGS_WIDTH-1:0] alu_type_i,
  input  logic [DATA_WIDTH-1:0] op1_i,
  input  logic [DATA_WIDTH-1:0] op2_i,
  output logic [DATA_WIDTH-1:0] res_o
);
  // Compare codes return their outcome in bit 0; JALR is rs1+imm with bit 0 cleared.
  localparam logic [ARGS_WIDTH-1:0] ALU_ADD  = ARGS_WIDTH'(0);
  localparam logic [ARGS_WIDTH-1:0] ALU_SUB  = ARGS_WIDTH'(1);
  localparam logic [ARGS_WIDTH-1:0] ALU_SLL  = ARGS_WIDTH'(2);
  localparam logic [ARGS_WIDTH-1:0] ALU_SLT  = ARGS_WIDTH'(3);
  localparam logic [ARGS_WIDTH-1:0] ALU_SLTU = ARGS_WIDTH'(4);
  localparam logic [ARGS_WIDTH-1:0] ALU_XOR  = ARGS_WIDTH'(5);
  localparam logic [ARGS_WIDTH-1:0] ALU_SRL  = ARGS_WIDTH'(6);
  localparam logic [ARGS_WIDTH-1:0] ALU_SRA  = ARGS_WIDTH'(7);
  localparam logic [ARGS_WIDTH-1:0] ALU_OR   = ARGS_WIDTH'(8);
  localparam logic [ARGS_WIDTH-1:0] ALU_AND  = ARGS_WIDTH'(9);
  localparam logic [ARGS_WIDTH-1:0] ALU_EQ   = ARGS_WIDTH'(10);
  localparam logic [ARGS_WIDTH-1:0] ALU_NE   = ARGS_WIDTH'(11);
  localparam logic [ARGS_WIDTH-1:0] ALU_LT   = ARGS_WIDTH'(12);
  localparam logic [ARGS_WIDTH-1:0] ALU_GE   = ARGS_WIDTH'(13);
  localparam logic [ARGS_WIDTH-1:0] ALU_LTU  = ARGS_WIDTH'(14);
  localparam logic [ARGS_WIDTH-1:0] ALU_GEU  = ARGS_WIDTH'(15);
  localparam logic [ARGS_WIDTH-1:0] ALU_JALR = ARGS_WIDTH'(16);
  localparam int SHW = $clog2(DATA_WIDTH);

  logic [SHW-1:0]        shamt;
  logic [DATA_WIDTH-1:0] sum;
  logic                  lt_s, lt_u, eq;

  assign shamt = op2_i[SHW-1:0];
  assign sum   = op1_i + op2_i;
  assign lt_s  = $signed(op1_i) < $signed(op2_i);
  assign lt_u  = op1_i < op2_i;
  assign eq    = op1_i == op2_i;

  always_comb begin
    res_o = '0;
    case (alu_type_i)
      ALU_ADD:  res_o = sum;
      ALU_SUB:  res_o = op1_i - op2_i;
      ALU_SLL:  res_o = op1_i << shamt;
      ALU_SLT:  res_o = DATA_WIDTH'(lt_s);
      ALU_SLTU: res_o = DATA_WIDTH'(lt_u);
      ALU_XOR:  res_o = op1_i ^ op2_i;
      ALU_SRL:  res_o = op1_i >> shamt;
      ALU_SRA:  res_o = $signed(op1_i) >>> shamt;
      ALU_OR:   res_o = op1_i | op2_i;
      ALU_AND:  res_o = op1_i & op2_i;
      ALU_EQ:   res_o = DATA_WIDTH'(eq);
      ALU_NE:   res_o = DATA_WIDTH'(~eq);
      ALU_LT:   res_o = DATA_WIDTH'(lt_s);
      ALU_GE:   res_o = DATA_WIDTH'(~lt_s);
      ALU_LTU:  res_o = DATA_WIDTH'(lt_u);
      ALU_GEU:  res_o = DATA_WIDTH'(~lt_u);
      ALU_JALR: res_o = sum & {{(DATA_WIDTH-1){1'b1}}, 1'b0};
      default:  res_o = '0;
    endcase
  end
endmodule

module exu_stage #(
  parameter int DATA_WIDTH = 32,
  parameter int ARGS_WIDTH = 5
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_flush,
  input  logic                  i_id_valid,
  output logic                  o_id_ready,
  input  logic [DATA_WIDTH-1:0] i_id_pc,
  input  logic [DATA_WIDTH-1:0] i_id_rs1_data,
  input  logic [DATA_WIDTH-1:0] i_id_rs2_data,
  input  logic [DATA_WIDTH-1:0] i_id_imm,
  input  logic [ARGS_WIDTH-1:0] i_id_alu_type,
  input  logic                  i_id_src1_pc,
  input  logic                  i_id_src2_imm,
  input  logic                  i_id_br,
  input  logic                  i_id_jal,
  input  logic                  i_id_jalr,
  input  logic [4:0]            i_id_rd_addr,
  input  logic                  i_id_rd_wen,
  output logic                  o_ex_valid,
  input  logic                  i_ex_ready,
  output logic [DATA_WIDTH-1:0] o_ex_pc,
  output logic [DATA_WIDTH-1:0] o_ex_res,
  output logic [DATA_WIDTH-1:0] o_ex_rs2_data,
  output logic [4:0]            o_ex_rd_addr,
  output logic                  o_ex_rd_wen,
  output logic                  o_ex_redirect,
  output logic [DATA_WIDTH-1:0] o_ex_redirect_pc
);
  localparam logic [ARGS_WIDTH-1:0] ALU_JALR = ARGS_WIDTH'(16);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t                state_q, state_d;
  logic                  redirect_q, redirect_d;
  logic [DATA_WIDTH-1:0] pc_q, pc_d, res_q, res_d, rs2_q, rs2_d, rpc_q, rpc_d;
  logic [4:0]            rd_q, rd_d;
  logic                  wen_q, wen_d;

  logic                  accept, taken, is_jump;
  logic [DATA_WIDTH-1:0] op1, op2, alu_res, br_target, link;
  logic [ARGS_WIDTH-1:0] alu_type;

  assign o_id_ready = (~o_ex_valid | i_ex_ready) & ~redirect_q & ~i_rst;
  assign accept     = i_id_valid & o_id_ready & ~i_flush;
  assign is_jump    = i_id_jal | i_id_jalr;

  // Branches compare rs1/rs2; JALR always takes rs1+imm through the ALU's JALR path.
  assign op1      = (i_id_src1_pc & ~i_id_br & ~i_id_jalr) ? i_id_pc : i_id_rs1_data;
  assign op2      = ((i_id_src2_imm & ~i_id_br) | i_id_jalr) ? i_id_imm : i_id_rs2_data;
  assign alu_type = i_id_jalr ? ALU_JALR : i_id_alu_type;

  exu_alu #(.DATA_WIDTH(DATA_WIDTH), .ARGS_WIDTH(ARGS_WIDTH)) u_alu (
    .alu_type_i (alu_type),
    .op1_i      (op1),
    .op2_i      (op2),
    .res_o      (alu_res)
  );

  assign br_target = i_id_pc + i_id_imm;
  assign link      = i_id_pc + DATA_WIDTH'(4);
  assign taken     = (i_id_br & alu_res[0]) | is_jump;

  always_comb begin
    state_d    = state_q;
    redirect_d = 1'b0;
    pc_d       = pc_q;
    res_d      = res_q;
    rs2_d      = rs2_q;
    rd_d       = rd_q;
    wen_d      = wen_q;
    rpc_d      = rpc_q;
    if (accept) begin
      state_d    = FULL;
      redirect_d = taken;
      pc_d       = i_id_pc;
      res_d      = i_id_br ? '0 : (is_jump ? link : alu_res);
      rs2_d      = i_id_rs2_data;
      rd_d       = i_id_rd_addr;
      wen_d      = i_id_rd_wen & ~i_id_br;
      rpc_d      = i_id_jalr ? alu_res : br_target;
    end else if (i_ex_ready) begin
      state_d = EMPTY;
    end
    if (i_flush) begin
      state_d    = EMPTY;
      redirect_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= EMPTY;
      redirect_q <= 1'b0;
      pc_q       <= '0;
      res_q      <= '0;
      rs2_q      <= '0;
      rd_q       <= '0;
      wen_q      <= 1'b0;
      rpc_q      <= '0;
    end else begin
      state_q    <= state_d;
      redirect_q <= redirect_d;
      pc_q       <= pc_d;
      res_q      <= res_d;
      rs2_q      <= rs2_d;
      rd_q       <= rd_d;
      wen_q      <= wen_d;
      rpc_q      <= rpc_d;
    end
  end

  assign o_ex_valid       = (state_q == FULL);
  assign o_ex_pc          = pc_q;
  assign o_ex_res         = res_q;
  assign o_ex_rs2_data    = rs2_q;
  assign o_ex_rd_addr     = rd_q;
  assign o_ex_rd_wen      = wen_q;
  assign o_ex_redirect    = redirect_q;
  assign o_ex_redirect_pc = rpc_q;
endmodule

// File: tb/tb_exu_stage.sv
// Scoreboard bench for exu_stage: driver pushes expected entries on accept, monitor
// pops/compares as the consumer takes them; directed cases followed by random traffic.
module tb_exu_stage;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int T_ADD = 0, T_SUB = 1, T_SLL = 2, T_SLT = 3, T_SLTU = 4, T_XOR = 5;
  localparam int T_SRL = 6, T_SRA = 7, T_OR = 8, T_AND = 9;
  localparam int T_BEQ = 10, T_BNE = 11, T_BLT = 12, T_BGE = 13, T_BLTU = 14, T_BGEU = 15;
  localparam int T_JALR = 16;

  logic i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  logic          i_rst, i_flush, i_id_valid, o_id_ready;
  logic [DW-1:0] i_id_pc, i_id_rs1_data, i_id_rs2_data, i_id_imm;
  logic [AW-1:0] i_id_alu_type;
  logic          i_id_src1_pc, i_id_src2_imm, i_id_br, i_id_jal, i_id_jalr;
  logic [4:0]    i_id_rd_addr;
  logic          i_id_rd_wen, o_ex_valid, i_ex_ready;
  logic [DW-1:0] o_ex_pc, o_ex_res, o_ex_rs2_data, o_ex_redirect_pc;
  logic [4:0]    o_ex_rd_addr;
  logic          o_ex_rd_wen, o_ex_redirect;

  exu_stage #(.DATA_WIDTH(DW), .ARGS_WIDTH(AW)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_flush(i_flush),
    .i_id_valid(i_id_valid), .o_id_ready(o_id_ready),
    .i_id_pc(i_id_pc), .i_id_rs1_data(i_id_rs1_data), .i_id_rs2_data(i_id_rs2_data),
    .i_id_imm(i_id_imm), .i_id_alu_type(i_id_alu_type),
    .i_id_src1_pc(i_id_src1_pc), .i_id_src2_imm(i_id_src2_imm),
    .i_id_br(i_id_br), .i_id_jal(i_id_jal), .i_id_jalr(i_id_jalr),
    .i_id_rd_addr(i_id_rd_addr), .i_id_rd_wen(i_id_rd_wen),
    .o_ex_valid(o_ex_valid), .i_ex_ready(i_ex_ready),
    .o_ex_pc(o_ex_pc), .o_ex_res(o_ex_res), .o_ex_rs2_data(o_ex_rs2_data),
    .o_ex_rd_addr(o_ex_rd_addr), .o_ex_rd_wen(o_ex_rd_wen),
    .o_ex_redirect(o_ex_redirect), .o_ex_redirect_pc(o_ex_redirect_pc)
  );

  typedef struct {
    logic [DW-1:0] pc, res, rs2, rpc;
    logic [4:0]    rd;
    logic          wen, redir;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   errors = 0;
  int   checks = 0;
  bit   rst_clean = 1'b0;
  bit   mon_en = 1'b0;
  bit   first_seen;
  bit   exp_rd;

  task automatic chk(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] alu_ref(int t, logic [DW-1:0] a, logic [DW-1:0] b);
    case (t)
      T_ADD:  return a + b;
      T_SUB:  return a - b;
      T_SLL:  return a << b[4:0];
      T_SLT:  return ($signed(a) < $signed(b)) ? 1 : 0;
      T_SLTU: return (a < b) ? 1 : 0;
      T_XOR:  return a ^ b;
      T_SRL:  return a >> b[4:0];
      T_SRA:  return $signed(a) >>> b[4:0];
      T_OR:   return a | b;
      T_AND:  return a & b;
      default: return 0;
    endcase
  endfunction

  function automatic bit br_cond(int t, logic [DW-1:0] a, logic [DW-1:0] b);
    case (t)
      T_BEQ:  return a == b;
      T_BNE:  return a != b;
      T_BLT:  return $signed(a) < $signed(b);
      T_BGE:  return $signed(a) >= $signed(b);
      T_BLTU: return a < b;
      T_BGEU: return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  // Expected entry for the instruction currently presented by ID.
  function automatic exp_t model();
    exp_t e;
    e.pc = i_id_pc; e.rs2 = i_id_rs2_data; e.rd = i_id_rd_addr; e.wen = i_id_rd_wen;
    e.redir = 1'b0; e.rpc = 0;
    if (i_id_br) begin
      e.res = 0; e.wen = 1'b0;
      e.redir = br_cond(int'(i_id_alu_type), i_id_rs1_data, i_id_rs2_data);
      e.rpc = i_id_pc + i_id_imm;
    end else if (i_id_jal) begin
      e.res = i_id_pc + 4; e.redir = 1'b1; e.rpc = i_id_pc + i_id_imm;
    end else if (i_id_jalr) begin
      e.res = i_id_pc + 4; e.redir = 1'b1; e.rpc = (i_id_rs1_data + i_id_imm) & ~32'h1;
    end else begin
      e.res = alu_ref(int'(i_id_alu_type), i_id_src1_pc ? i_id_pc : i_id_rs1_data,
                      i_id_src2_imm ? i_id_imm : i_id_rs2_data);
    end
    return e;
  endfunction

  // Called at posedge+1 with inputs set; records acceptance just before the next edge.
  task automatic tick();
    @(negedge i_clk); #1;
    if (i_rst) begin
      q.delete(); rst_clean = 1'b1;
    end else if (i_id_valid && o_id_ready && !i_flush) begin
      q.push_back(model()); rst_clean = 1'b0;
    end
    @(posedge i_clk); #1;
  endtask

  task automatic set_op(logic [DW-1:0] pc, logic [DW-1:0] rs1, logic [DW-1:0] rs2,
                        logic [DW-1:0] imm, int ty, bit s1pc, bit s2imm,
                        bit br, bit jal, bit jalr, logic [4:0] rd, bit wen);
    i_id_pc = pc; i_id_rs1_data = rs1; i_id_rs2_data = rs2; i_id_imm = imm;
    i_id_alu_type = AW'(ty); i_id_src1_pc = s1pc; i_id_src2_imm = s2imm;
    i_id_br = br; i_id_jal = jal; i_id_jalr = jalr; i_id_rd_addr = rd; i_id_rd_wen = wen;
  endtask

  task automatic rand_op();
    int k;
    logic [DW-1:0] a, b;
    k = $urandom_range(0, 9);
    a = ($urandom_range(0, 1) == 1) ? $urandom : DW'($urandom_range(0, 15));
    b = ($urandom_range(0, 2) == 0) ? a :
        (($urandom_range(0, 1) == 1) ? $urandom : DW'($urandom_range(0, 15)));
    set_op($urandom, a, b, $urandom, $urandom_range(0, 9), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0, 5'($urandom), 1'($urandom_range(0, 1)));
    if (k >= 6 && k < 8) begin
      i_id_br = 1'b1; i_id_alu_type = AW'($urandom_range(T_BEQ, T_BGEU));
    end else if (k == 8) begin
      i_id_jal = 1'b1; i_id_alu_type = AW'(T_ADD);
    end else if (k == 9) begin
      i_id_jalr = 1'b1; i_id_alu_type = AW'(T_JALR);
    end
  endtask

  // Monitor: compares the front entry whenever the DUT presents one.
  initial begin
    wait (mon_en);
    first_seen = 1'b1;
    forever begin
      @(posedge i_clk); #3;
      if (i_rst) begin
        chk("ready_in_reset", 32'(o_id_ready), 0);
        first_seen = 1'b1;
      end else if (q.size() == 0) begin
        chk("idle_valid", 32'(o_ex_valid), 0);
        chk("idle_redirect", 32'(o_ex_redirect), 0);
        chk("idle_ready", 32'(o_id_ready), 1);
        if (rst_clean) begin
          chk("rst_pc", o_ex_pc, 0);
          chk("rst_res", o_ex_res, 0);
          chk("rst_rs2", o_ex_rs2_data, 0);
          chk("rst_rd", 32'(o_ex_rd_addr), 0);
          chk("rst_wen", 32'(o_ex_rd_wen), 0);
          chk("rst_rpc", o_ex_redirect_pc, 0);
        end
        first_seen = 1'b1;
      end else begin
        mon_e  = q[0];
        exp_rd = first_seen && mon_e.redir;
        chk("valid", 32'(o_ex_valid), 1);
        chk("redirect", 32'(o_ex_redirect), 32'(exp_rd));
        if (exp_rd) chk("redirect_pc", o_ex_redirect_pc, mon_e.rpc);
        chk("pc", o_ex_pc, mon_e.pc);
        chk("res", o_ex_res, mon_e.res);
        chk("rs2", o_ex_rs2_data, mon_e.rs2);
        chk("rd", 32'(o_ex_rd_addr), 32'(mon_e.rd));
        chk("wen", 32'(o_ex_rd_wen), 32'(mon_e.wen));
        chk("ready", 32'(o_id_ready), 32'(i_ex_ready && !exp_rd));
        first_seen = 1'b0;
        if (i_flush) begin
          q.delete(); first_seen = 1'b1;
        end else if (i_ex_ready) begin
          void'(q.pop_front()); first_seen = 1'b1;
        end
      end
    end
  end

  initial begin
    i_rst = 1'b1; i_flush = 1'b0; i_id_valid = 1'b0; i_ex_ready = 1'b0;
    set_op(0, 0, 0, 0, T_ADD, 0, 0, 0, 0, 0, 0, 0);
    @(posedge i_clk); #1;
    @(posedge i_clk); #1;
    chk("reset_valid", 32'(o_ex_valid), 0);
    chk("reset_redirect", 32'(o_ex_redirect), 0);
    chk("reset_res", o_ex_res, 0);
    i_rst = 1'b0; rst_clean = 1'b1; q.delete(); mon_en = 1'b1;
    tick();

    // ADD x3 = 7 + 5
    set_op(32'h40, 7, 5, 0, T_ADD, 0, 0, 0, 0, 0, 3, 1);
    i_id_valid = 1'b1; i_ex_ready = 1'b1; tick();
    i_id_valid = 1'b0; #1;
    chk("add_valid", 32'(o_ex_valid), 1);
    chk("add_res", o_ex_res, 12);
    chk("add_rd", 32'(o_ex_rd_addr), 3);
    chk("add_wen", 32'(o_ex_rd_wen), 1);
    tick();

    // Consumer stall for three cycles, then drain
    set_op(32'h44, 1, 2, 0, T_ADD, 0, 0, 0, 0, 0, 4, 1);
    i_id_valid = 1'b1; i_ex_ready = 1'b1; tick();
    set_op(32'h48, 9, 9, 0, T_ADD, 0, 0, 0, 0, 0, 5, 1);
    i_ex_ready = 1'b0;
    repeat (3) begin
      #1;
      chk("stall_ready", 32'(o_id_ready), 0);
      chk("stall_res", o_ex_res, 3);
      chk("stall_pc", o_ex_pc, 32'h44);
      tick();
    end
    i_ex_ready = 1'b1; i_id_valid = 1'b0; tick();
    #1 chk("drain_valid", 32'(o_ex_valid), 0);

    // Taken BEQ; operand-select bits set to prove the branch forces rs1/rs2
    set_op(32'h100, 4, 4, 32'h20, T_BEQ, 1, 1, 1, 0, 0, 7, 1);
    i_id_valid = 1'b1; tick();
    set_op(32'h104, 1, 1, 0, T_ADD, 0, 0, 0, 0, 0, 8, 1);
    #1;
    chk("beq_redirect", 32'(o_ex_redirect), 1);
    chk("beq_target", o_ex_redirect_pc, 32'h120);
    chk("beq_wen", 32'(o_ex_rd_wen), 0);
    chk("beq_ready_drop", 32'(o_id_ready), 0);
    tick();
    i_id_valid = 1'b0;
    #1 chk("beq_pulse_end", 32'(o_ex_redirect), 0);
    tick();

    // JALR target clears bit 0, link = pc + 4
    set_op(32'h80, 32'h203, 0, 32'h10, T_JALR, 0, 1, 0, 0, 1, 1, 1);
    i_id_valid = 1'b1; tick();
    i_id_valid = 1'b0; #1;
    chk("jalr_target", o_ex_redirect_pc, 32'h212);
    chk("jalr_link", o_ex_res, 32'h84);
    chk("jalr_redirect", 32'(o_ex_redirect), 1);
    tick();

    // Flush while FULL and stalled, then flush a JAL into an empty stage
    set_op(32'h200, 10, 20, 0, T_ADD, 0, 0, 0, 0, 0, 9, 1);
    i_id_valid = 1'b1; i_ex_ready = 1'b0; tick();
    set_op(32'h300, 0, 0, 32'h40, T_ADD, 0, 0, 0, 1, 0, 1, 1);
    i_flush = 1'b1; tick();
    #1;
    chk("flush_valid", 32'(o_ex_valid), 0);
    chk("flush_redirect", 32'(o_ex_redirect), 0);
    i_ex_ready = 1'b1; tick();
    i_flush = 1'b0; i_id_valid = 1'b0; #1;
    chk("flush_empty_valid", 32'(o_ex_valid), 0);
    chk("flush_empty_redirect", 32'(o_ex_redirect), 0);
    tick();

    // Reset mid-stall, then back-to-back ADDs without bubbles
    set_op(32'h400, 3, 4, 0, T_ADD, 0, 0, 0, 0, 0, 2, 1);
    i_id_valid = 1'b1; tick();
    i_id_valid = 1'b0; i_ex_ready = 1'b0; tick();
    i_rst = 1'b1; tick();
    i_rst = 1'b0; #1;
    chk("midrst_valid", 32'(o_ex_valid), 0);
    chk("midrst_res", o_ex_res, 0);
    chk("midrst_pc", o_ex_pc, 0);
    i_ex_ready = 1'b1; i_id_valid = 1'b1;
    for (int n = 0; n < 4; n++) begin
      set_op(32'h500 + 32'(n * 4), 32'(n), 100, 0, T_ADD, 0, 0, 0, 0, 0, 5'(n + 1), 1);
      #1 chk("b2b_ready", 32'(o_id_ready), 1);
      tick();
    end
    i_id_valid = 1'b0; tick();

    // Random traffic
    for (int c = 0; c < 1500; c++) begin
      i_rst      = ($urandom_range(0, 99) == 0);
      i_flush    = !i_rst && ($urandom_range(0, 19) == 0);
      i_id_valid = ($urandom_range(0, 3) != 0);
      i_ex_ready = ($urandom_range(0, 3) != 0);
      rand_op();
      tick();
    end
    i_rst = 1'b0; i_flush = 1'b0; i_id_valid = 1'b0; i_ex_ready = 1'b1;
    repeat (3) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
